// File: rtl/hex_display_scanner_pkg.sv
// Shared display definitions: blank pattern, scan states and segment bit order.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package hex_display_scanner_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_e;

endpackage

// File: rtl/hex_display_scanner_hex7seg.sv
// Active-low hex to 7-segment decoder, output ordered {g,f,e,d,c,b,a}.
module hex_display_scanner_hex7seg
  import hex_display_scanner_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      4'hF: seg_n_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed common-anode 7-segment scanner with guard band,
// frame-synchronous double-buffered value, blanking and zero suppression.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lzs_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int TW = $clog2(DWELL_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] TICK_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ON   = TW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  load_ready_q;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_end;
  logic                  wrap;
  logic                  accept;
  logic [NUM_DIGITS-1:0] dark;
  logic                  digit_dark;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;

  always_comb begin
    slot_end = (tick_q == TICK_LAST);
    wrap     = slot_end && (digit_q == DIG_LAST);
    tick_d   = slot_end ? '0 : tick_q + 1'b1;
    digit_d  = digit_q;
    if (slot_end) begin
      digit_d = wrap ? '0 : digit_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BLANK: if (tick_d >= TICK_ON) state_d = S_ON;
      S_ON:    if (slot_end) state_d = S_BLANK;
    endcase
  end

  // load_ready mirrors !pending, so accept and commit are exclusive
  always_comb begin
    accept    = load_valid && load_ready_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (accept) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // a digit is a leading zero when it and every digit above it are 0
  always_comb begin
    dark = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dark[i] = blank_mask[i] ||
                (lzs_en && (i != 0) && ((active_q >> (4 * i)) == '0));
    end
  end

  always_comb begin
    nibble     = '0;
    digit_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DW'(i)) begin
        nibble     = active_q[4*i +: 4];
        digit_dark = dark[i];
      end
    end
  end

  hex_display_scanner_hex7seg u_hex7seg (
    .hex_i   (nibble),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    an_n_d       = '1;
    seg_n_d      = SEG_BLANK;
    frame_tick_d = wrap;
    if (state_q == S_ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_q == DW'(i)) an_n_d[i] = 1'b0;
      end
      seg_n_d = digit_dark ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BLANK;
      tick_q       <= '0;
      digit_q      <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      an_n_q       <= '1;
      seg_n_q      <= SEG_BLANK;
      load_ready_q <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      digit_q      <= digit_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      load_ready_q <= !pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign load_ready = load_ready_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: cycle-level reference model plus
// table-driven and directed display/handshake/reset sequences.
module tb_hex_display_scanner;

  localparam int ND = 4;
  localparam int DW = 8;
  localparam int BL = 2;
  localparam int FR = ND * DW;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  blank_mask;
  logic        lzs_en;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_mask (blank_mask),
    .lzs_en     (lzs_en),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Reference model: m_n counts clock edges since reset; slot position and
  // digit follow from plain division, the value is a frame-level buffer.
  int          m_n;
  int          m_p;
  int          m_d;
  logic [15:0] m_act;
  logic [15:0] m_sh;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_rdy;
  logic        e_ft;
  bit          chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n    = 0;
      m_act  = '0;
      m_sh   = '0;
      m_pend = 1'b0;
      e_an   = 4'hF;
      e_seg  = 7'h7F;
      e_rdy  = 1'b1;
      e_ft   = 1'b0;
    end else begin
      m_p   = m_n % DW;
      m_d   = (m_n / DW) % ND;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (m_p >= BL) begin
        e_an = 4'hF ^ (4'b0001 << m_d);
        if (!(blank_mask[m_d] ||
              (lzs_en && m_d != 0 && (m_act >> (4 * m_d)) == 16'h0)))
          e_seg = ref_seg(m_act[4*m_d +: 4]);
      end
      e_ft = (m_n % FR) == FR - 1;
      if (e_ft && m_pend) begin
        m_act  = m_sh;
        m_pend = 1'b0;
      end else if (load_valid && !m_pend) begin
        m_sh   = load_data;
        m_pend = 1'b1;
      end
      e_rdy = !m_pend;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({an_n, seg_n, load_ready, frame_tick} !==
          {e_an, e_seg, e_rdy, e_ft}) begin
        failures++;
        if (failures < 20)
          $display("FAIL model t=%0t an=%h/%h seg=%h/%h rdy=%b/%b ft=%b/%b",
                   $time, an_n, e_an, seg_n, e_seg,
                   load_ready, e_rdy, frame_tick, e_ft);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] pat);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (an_n === pat) return;
    end
    check("an_timeout", {28'h0, an_n}, {28'h0, pat});
  endtask

  task automatic wait_ft();
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (frame_tick === 1'b1) return;
    end
    check("frame_tick_timeout", frame_tick, 1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 80; i++) begin
      if (load_ready === 1'b1) return;
      @(posedge clk);
      #1;
    end
    check("ready_timeout", load_ready, 1);
  endtask

  task automatic do_load(input logic [15:0] v);
    wait_ready();
    load_valid = 1'b1;
    load_data  = v;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    check("ready_low_after_accept", load_ready, 0);
  endtask

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      mask;
    logic            lzs;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t       vecs [4];
  int         ft_at;
  logic [3:0] pat;

  initial begin
    vecs[0] = '{16'h1A3F, 4'h0, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}};
    vecs[1] = '{16'h0040, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}};
    vecs[2] = '{16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h1234, 4'h5, 1'b0, {7'h79, 7'h7F, 7'h30, 7'h7F}};

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    blank_mask = '0;
    lzs_en     = 1'b0;
    #12;
    check("rst_an", an_n, 4'hF);
    check("rst_seg", seg_n, 7'h7F);
    check("rst_ready", load_ready, 1);
    check("rst_ft", frame_tick, 0);
    #11;
    rst    = 1'b0;
    chk_en = 1'b1;

    ft_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (frame_tick && ft_at == 0) ft_at = k;
    end
    check("first_frame_tick_cycle", ft_at, 32);

    for (int t = 0; t < 4; t++) begin
      blank_mask = vecs[t].mask;
      lzs_en     = vecs[t].lzs;
      repeat (5) @(posedge clk);
      #1;
      do_load(vecs[t].val);
      wait_ft();
      check("ready_after_commit", load_ready, 1);
      for (int d = 0; d < 4; d++) begin
        pat = 4'b0001 << d;
        pat = ~pat;
        wait_an(pat);
        check($sformatf("vec%0d_dig%0d", t, d), seg_n, vecs[t].exp[d]);
      end
    end

    blank_mask = '0;
    lzs_en     = 1'b0;
    wait_ready();
    load_valid = 1'b1;
    load_data  = 16'h1111;
    @(posedge clk);
    #1;
    check("b2b_ready_low", load_ready, 0);
    load_data = 16'h2222;
    for (int i = 0; i < 80 && load_ready !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_ready_at_wrap", frame_tick, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("b2b_second_accept", load_ready, 0);
    wait_an(4'b1110);
    check("b2b_first_frame", seg_n, 7'h79);
    wait_ft();
    wait_an(4'b1110);
    check("b2b_second_frame", seg_n, 7'h24);

    for (int c = 0; c < 700; c++) begin
      @(posedge clk);
      #1;
      load_valid = ($urandom_range(0, 5) == 0);
      load_data  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 39) == 0) lzs_en = 1'($urandom);
    end
    load_valid = 1'b0;
    blank_mask = '0;
    lzs_en     = 1'b0;

    wait_ft();
    do_load(16'h5678);
    wait_an(4'b1011);
    rst = 1'b1;
    #1;
    check("async_rst_an", an_n, 4'hF);
    check("async_rst_seg", seg_n, 7'h7F);
    check("async_rst_ready", load_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_ready", load_ready, 1);
    wait_an(4'b1110);
    check("post_rst_dig0", seg_n, 7'h40);
    wait_an(4'b1101);
    check("post_rst_dig1", seg_n, 7'h40);
    wait_ft();
    wait_an(4'b1110);
    check("pending_dropped", seg_n, 7'h40);

    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed controller for a bank of common-anode 7-segment digits that share one active-low hex decoder. It holds the displayed value in a frame-synchronous double buffer. It scans one digit at a time with an anode-off guard band to prevent ghosting, and supports per-digit blanking and leading-zero suppression. It sits between the counter/FSM logic that produces display values and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2).
DWELL_CYCLES, 50000, clk cycles per digit slot, guard band included.
BLANK_CYCLES, 500, guard cycles at the start of each slot with all anodes off (1 <= BLANK_CYCLES < DWELL_CYCLES).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  requester offers a new display value.
load_data  input  4*NUM_DIGITS  packed nibbles; digit i = bits [4i+3:4i]; digit 0 is rightmost.
load_ready  output  1  high when a load can be accepted.
blank_mask  input  NUM_DIGITS  bit i = 1 forces digit i dark; applied live.
lzs_en  input  1  enables leading-zero suppression; applied live.
seg_n  output  7  active-low segments {g,f,e,d,c,b,a}; 7'h7F = dark.
an_n  output  NUM_DIGITS  active-low anodes; at most one bit low.
frame_tick  output  1  one-cycle pulse at the frame boundary.

Behaviour:
- Reset is asynchronous, active-high, applied on assertion. Values: an_n all 1, seg_n 7'h7F, load_ready 1, frame_tick 0, active and shadow registers 0, pending 0, digit_idx 0, tick_cnt 0, state S_BLANK.
- Reset asserted mid-scan or mid-load drops any pending value. Scanning restarts at digit 0 in S_BLANK.
- States: S_BLANK and S_ON.
  - tick_cnt counts 0..DWELL_CYCLES-1 within each slot.
  - S_BLANK holds while tick_cnt < BLANK_CYCLES, then goes to S_ON.
  - At tick_cnt == DWELL_CYCLES-1: tick_cnt goes to 0, state goes to S_BLANK, and digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Outputs are registered, one cycle behind state.
  - S_BLANK: an_n all 1, seg_n 7'h7F.
  - S_ON: an_n has only bit digit_idx low. seg_n is the decode of active nibble[digit_idx], or 7'h7F if that digit is blanked.
- A digit is blanked if blank_mask[i] = 1, or if lzs_en = 1 and i != 0 and all active nibbles i..NUM_DIGITS-1 are zero.
  - Digit 0 is never suppressed by lzs_en; a value of 0 shows "0".
  - Example: 0x0040 with lzs_en shows "40" on digits 1..0; digits 3..2 are dark.
- Load handshake:
  - Transfer occurs when load_valid && load_ready. load_data is captured into shadow and pending is set.
  - load_ready = !pending, registered. It goes low the cycle after acceptance.
  - Commit: on the wrap cycle (digit_idx NUM_DIGITS-1 -> 0), if pending, shadow is copied to active and pending is cleared.
  - load_ready returns high the cycle after commit. No acceptance and commit can occur in the same cycle.
  - The active value never changes mid-frame, so no torn display.
  - load_valid held high while load_ready is low has no effect. load_data does not need to be held.
- frame_tick is 1 for exactly the cycle after each wrap; period NUM_DIGITS*DWELL_CYCLES cycles.
- Counter widths: $clog2(DWELL_CYCLES) for tick_cnt, $clog2(NUM_DIGITS) for digit_idx. digit_idx never reaches NUM_DIGITS.

Decomposition:
- Shared display package holds:
  - SEG_BLANK = 7'h7F;
  - state encodings S_BLANK = 1'b0 and S_ON = 1'b1;
  - the segment bit-order definition.
- One natural sub-module: the team's existing active-low hex-to-7-segment decoder (Hex7Seg). Instantiate it once on the muxed nibble; do not duplicate its table.
- Scanner counters, handshake and blanking logic stay in this module.

Test Plan:
Bench parameters NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
- Reset, then free-run 40 cycles -> an_n low pattern 1110,1101,1011,0111 repeats. Each digit is low 6 cycles, preceded by 2 cycles of 4'hF. seg_n = 7'h40 ("0") on digit 0 and 7'h40 on the others (lzs_en=0). frame_tick pulses every 32 cycles.
- Load 0x1A3F mid-frame -> load_ready low the next cycle. Display stays 0000 until the wrap. From the next frame, digits 0..3 show F (7'h0E), 3 (7'h30), A (7'h08), 1 (7'h79). load_ready returns high one cycle after the wrap.
- lzs_en=1, load 0x0040 -> digits 3 and 2 seg_n 7'h7F with their anodes still cycling; digit 1 shows 7'h19; digit 0 shows 7'h40. Load 0x0000 -> only digit 0 lit with 7'h40.
- blank_mask=4'b0101 with value 0x1234 -> digits 0 and 2 dark, digits 1 and 3 show 7'h30 and 7'h79. No anode is ever low together with seg_n not equal to the expected decode.
- Back-to-back loads: load_valid held high with 0x1111 then 0x2222 -> only one accepted per frame. 0x1111 displays for one full frame, then 0x2222.
- Assert rst for 1 cycle while digit 2 is in S_ON with a load pending -> outputs dark immediately (async). After release, scanning restarts at digit 0 showing 0x0000, and load_ready is 1.
